// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
// The data width is fixed here (XLEN) so the queued entry struct and the module ports always agree.
package riscv_wb_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RECOVER = 2'd2
    } wb_state_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending register writes. Besides the head it exports every slot in
// age order (index 0 = oldest) with a matching valid vector for busy and forwarding scans.
module wb_fifo
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] entry_valid,
    output wb_entry_t        entries [DEPTH]
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    wb_entry_t        r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; a slot is only observed while its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_entry;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k]     = r_mem[r_rd_ptr + PTR_W'(k)];
            entry_valid[k] = (CNT_W'(k) < r_count);
        end
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage owning the single register-file write port: queues ALU/load results and
// emits one Wen pulse per result with a low cycle between pulses. Define WB_FORWARD_EN for read-port forwarding.
module reg_writeback_unit
    import riscv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  Wen,
    output logic [REG_ADDR_W-1:0] Rd_addr,
    output logic [XLEN-1:0]       write_data,
    output logic [NUM_REGS-1:0]   busy_mask
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] Rs1_addr,
    input  logic [REG_ADDR_W-1:0] Rs2_addr,
    output logic                  rs1_fwd_hit,
    output logic                  rs2_fwd_hit,
    output logic [XLEN-1:0]       rs1_fwd_data,
    output logic [XLEN-1:0]       rs2_fwd_data
`endif
);

    wb_state_t             r_state;
    logic                  r_wen;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic [XLEN-1:0]       r_write_data;

    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    wb_entry_t             w_entries [DEPTH];
    logic [DEPTH-1:0]      w_valid;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ld_accept;
    logic                  w_alu_accept;
    logic [NUM_REGS-1:0]   w_busy;

    // Loads win arbitration; readiness looks only at registered occupancy, never at a same-cycle pop.
    assign ld_ready     = !w_full;
    assign alu_ready    = !w_full && !ld_valid;
    assign w_ld_accept  = ld_valid && ld_ready;
    assign w_alu_accept = alu_valid && alu_ready;

    // x0 results complete the handshake but are dropped here.
    assign w_push = (w_ld_accept && (ld_rd != '0)) || (w_alu_accept && (alu_rd != '0));
    assign w_pop  = (r_state == WRITE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_push_entry = '{rd: alu_rd, data: alu_data};
        if (ld_valid) w_push_entry = '{rd: ld_rd, data: ld_data};
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (w_push),
        .push_entry  (w_push_entry),
        .pop         (w_pop),
        .head        (w_head),
        .full        (w_full),
        .empty       (w_empty),
        .entry_valid (w_valid),
        .entries     (w_entries)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wen        <= 1'b0;
            r_rd_addr    <= '0;
            r_write_data <= '0;
        end else begin
            case (r_state)
                IDLE, RECOVER: begin
                    if (!w_empty) begin
                        r_state      <= WRITE;
                        r_wen        <= 1'b1;
                        r_rd_addr    <= w_head.rd;
                        r_write_data <= w_head.data;
                    end else begin
                        r_state <= IDLE;
                        r_wen   <= 1'b0;
                    end
                end
                WRITE: begin
                    r_state <= RECOVER;
                    r_wen   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign Wen        = r_wen;
    assign Rd_addr    = r_rd_addr;
    assign write_data = r_write_data;

    // The head keeps its busy bit through the WRITE cycle because it is popped on leaving WRITE.
    always_comb begin
        w_busy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k]) w_busy = w_busy | rd_onehot(w_entries[k].rd);
        end
    end

    assign busy_mask = w_busy & ~NUM_REGS'(1);

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        rs1_fwd_hit  = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_hit  = 1'b0;
        rs2_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k] && (Rs1_addr != '0) && (w_entries[k].rd == Rs1_addr)) begin
                rs1_fwd_hit  = 1'b1;
                rs1_fwd_data = w_entries[k].data;
            end
            if (w_valid[k] && (Rs2_addr != '0) && (w_entries[k].rd == Rs2_addr)) begin
                rs2_fwd_hit  = 1'b1;
                rs2_fwd_data = w_entries[k].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Scoreboard bench for reg_writeback_unit: accepted results are queued, every Wen pulse is
// popped and compared, and busy_mask/readiness are predicted from the queue contents.
module tb_reg_writeback_unit;
    import riscv_wb_pkg::*;

    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  alu_valid, ld_valid;
    logic [REG_ADDR_W-1:0] alu_rd, ld_rd;
    logic [XLEN-1:0]       alu_data, ld_data;
    logic                  alu_ready, ld_ready;
    logic                  Wen;
    logic [REG_ADDR_W-1:0] Rd_addr;
    logic [XLEN-1:0]       write_data;
    logic [NUM_REGS-1:0]   busy_mask;
`ifdef WB_FORWARD_EN
    logic [REG_ADDR_W-1:0] Rs1_addr, Rs2_addr;
    logic                  rs1_fwd_hit, rs2_fwd_hit;
    logic [XLEN-1:0]       rs1_fwd_data, rs2_fwd_data;
`endif

    int        n_tests = 0;
    int        n_fail  = 0;
    int        n_writes = 0;
    wb_entry_t sb_q [$];
    logic      prev_wen = 1'b0;
    logic [NUM_REGS-1:0] mon_busy;
    wb_entry_t           mon_e;

    reg_writeback_unit #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_valid   (ld_valid),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .Wen        (Wen),
        .Rd_addr    (Rd_addr),
        .write_data (write_data),
        .busy_mask  (busy_mask)
`ifdef WB_FORWARD_EN
        ,
        .Rs1_addr     (Rs1_addr),
        .Rs2_addr     (Rs2_addr),
        .rs1_fwd_hit  (rs1_fwd_hit),
        .rs2_fwd_hit  (rs2_fwd_hit),
        .rs1_fwd_data (rs1_fwd_data),
        .rs2_fwd_data (rs2_fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor on the falling edge: busy prediction, write ordering and pulse spacing.
    always @(negedge clk) begin
        if (!rst) begin
            mon_busy = '0;
            foreach (sb_q[i]) mon_busy = mon_busy | (NUM_REGS'(1) << sb_q[i].rd);
            check("busy_mask", busy_mask, mon_busy);
            if (Wen) begin
                check("wen_gap", prev_wen, 0);
                if (sb_q.size() == 0) begin
                    check("wen_unexpected", Wen, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("wr_rd", Rd_addr, mon_e.rd);
                    check("wr_data", write_data, mon_e.data);
                    n_writes++;
                end
            end
            prev_wen = Wen;
        end else begin
            prev_wen = 1'b0;
        end
    end

    // Offer a load and/or ALU result from the low clock phase until each is accepted.
    // Occupancy = queued entries plus the head being written (already popped by the monitor).
    task automatic offer(input logic lv, input logic [4:0] lrd, input logic [63:0] ldd,
                         input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         output int stalls);
        logic l_pend, a_pend, l_acc, a_acc, full_m;
        int   budget;
        l_pend = lv;
        a_pend = av;
        stalls = 0;
        budget = 0;
        while ((l_pend || a_pend) && budget < 64) begin
            ld_valid  = l_pend;
            ld_rd     = lrd;
            ld_data   = ldd;
            alu_valid = a_pend;
            alu_rd    = ard;
            alu_data  = ad;
            #1;
            full_m = (sb_q.size() + (Wen ? 1 : 0)) >= DEPTH;
            check("ld_ready", ld_ready, !full_m);
            check("alu_ready", alu_ready, !full_m && !l_pend);
            l_acc = l_pend && !full_m;
            a_acc = a_pend && !full_m && !l_pend;
            if (!l_acc && !a_acc) stalls++;
            @(posedge clk);
            if (l_acc) begin
                l_pend = 1'b0;
                if (lrd != 5'd0) sb_q.push_back('{rd: lrd, data: ldd});
            end
            if (a_acc) begin
                a_pend = 1'b0;
                if (ard != 5'd0) sb_q.push_back('{rd: ard, data: ad});
            end
            @(negedge clk);
            budget++;
        end
        ld_valid  = 1'b0;
        alu_valid = 1'b0;
        check("offer_timeout", {l_pend, a_pend}, 0);
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((sb_q.size() != 0 || Wen) && b < 200) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("drain", sb_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int st, total_st, w0, b;
        alu_valid = 1'b0; ld_valid = 1'b0;
        alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
`ifdef WB_FORWARD_EN
        Rs1_addr = '0; Rs2_addr = '0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_wen", Wen, 0);
        check("rst_rd_addr", Rd_addr, 0);
        check("rst_wdata", write_data, 0);
        check("rst_busy", busy_mask, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single ALU result: one-cycle Wen starting at edge 1, values held afterwards.
        offer(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h1234, st);
        check("t1_wen_e0", Wen, 0);
        check("t1_busy_e0", busy_mask[5], 1);
        @(negedge clk); #1;
        check("t1_wen_e1", Wen, 1);
        check("t1_rd_e1", Rd_addr, 5);
        check("t1_data_e1", write_data, 64'h1234);
        check("t1_busy_e1", busy_mask[5], 1);
        @(negedge clk); #1;
        check("t1_wen_e2", Wen, 0);
        check("t1_rd_hold", Rd_addr, 5);
        check("t1_data_hold", write_data, 64'h1234);
        check("t1_busy_e2", busy_mask, 0);
        @(negedge clk);
        wait_drain();

        // Load and ALU together: load first, ALU after a Wen-low cycle.
        w0 = n_writes;
        offer(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44, st);
        wait_drain();
        check("t2_writes", n_writes - w0, 2);

        // Burst longer than the FIFO: stalls must appear, order is checked by the monitor.
        w0 = n_writes;
        total_st = 0;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 5'(8 + i), 64'hA00 + 64'(i), 1'b0, 5'd0, 64'd0, st);
            total_st += st;
        end
        check("t3_stalled", total_st > 0, 1);
        wait_drain();
        check("t3_writes", n_writes - w0, 8);

        // x0 destination: accepted, never written, never busy.
        w0 = n_writes;
        offer(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'd0, st);
        check("t4_busy", busy_mask, 0);
        repeat (6) @(negedge clk);
        check("t4_writes", n_writes - w0, 0);

        // Reset during a write with entries still queued.
        offer(1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'h20, st);
        offer(1'b0, 5'd0, 64'd0, 1'b1, 5'd21, 64'h21, st);
        offer(1'b0, 5'd0, 64'd0, 1'b1, 5'd22, 64'h22, st);
        b = 0;
        #1;
        while (!Wen && b < 20) begin
            @(negedge clk); #1;
            b++;
        end
        check("t5_wen_seen", Wen, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_wen_async", Wen, 0);
        check("t5_busy_rst", busy_mask, 0);
        check("t5_rd_rst", Rd_addr, 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        w0 = n_writes;
        repeat (10) @(negedge clk);
        check("t5_no_writes", n_writes - w0, 0);
        check("t5_ld_ready", ld_ready, 1);

`ifdef WB_FORWARD_EN
        // Two queued writes to x10: youngest data forwards, x0 never hits.
        offer(1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'h2, st);
        offer(1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 64'h7, st);
        Rs1_addr = 5'd10;
        Rs2_addr = 5'd0;
        #1;
        check("t6_rs1_hit", rs1_fwd_hit, 1);
        check("t6_rs1_data", rs1_fwd_data, 64'h7);
        check("t6_rs2_hit", rs2_fwd_hit, 0);
        @(negedge clk);
        wait_drain();
        #1;
        check("t6_rs1_hit_empty", rs1_fwd_hit, 0);
`endif

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
